divisor_param: RTL

Parametrised sequential restoring divider: unsigned WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
- Produces quotient and remainder, a one-cycle done pulse, busy status and a divide-by-zero flag.
- Replaces the fixed 3-bit divider in the lab datapath; results hold stable until the next accepted start.

---
 rtl/divisor_pkg.sv | 13 +
 rtl/divisor_paso.sv | 26 ++
 rtl/divisor_param.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/divisor_pkg.sv
// Shared constants for the parametrised restoring divider.
// State encoding and the default operand width.
package divisor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divisor_paso.sv
// One combinational restoring-division step: shift the accumulator left,
// then subtract the divisor from the upper half when it fits.
module divisor_paso
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0]   i_dr,
    output logic [2*WIDTH-1:0] o_a,
    output logic               o_z
);

    logic [WIDTH:0] w_upper;
    logic [WIDTH:0] w_diff;

    // Upper half after the shift keeps the bit shifted out of the top, so the
    // compare/subtract is WIDTH+1 bits wide; the borrow is the compare result.
    assign w_upper = i_a[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_upper - {1'b0, i_dr};
    assign o_z     = ~w_diff[WIDTH];

    assign o_a = {(o_z ? w_diff[WIDTH-1:0] : w_upper[WIDTH-1:0]),
                  i_a[WIDTH-2:0], o_z};

endmodule

// File: rtl/divisor_param.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIVISOR_DEBUG_EN to expose internal counter/accumulator test ports.
module divisor_param
    import divisor_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   DV,
    input  logic [WIDTH-1:0]   DR,
    output logic [WIDTH-1:0]   cociente,
    output logic [WIDTH-1:0]   residuo,
    output logic               done,
    output logic               busy,
    output logic               div0
`ifdef DIVISOR_DEBUG_EN
    ,
    output logic [CNT_W-1:0]   testN,
    output logic               testZ,
    output logic               testDone,
    output logic [2*WIDTH-1:0] testDV,
    output logic               testdv0
`endif
);

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_dr;
    logic [WIDTH-1:0]     r_coc;
    logic [WIDTH-1:0]     r_res;
    logic                 r_div0;
    logic [2*WIDTH-1:0]   w_step_a;
    logic                 w_step_z;

    divisor_paso #(
        .WIDTH (WIDTH)
    ) u_paso (
        .i_a  (r_acc),
        .i_dr (r_dr),
        .o_a  (w_step_a),
        .o_z  (w_step_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (DR != '0) ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_CALC: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Results are written on the edge that enters DONE and then hold until
    // the next operation finishes; a zero divisor short-circuits to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_dr   <= '0;
            r_coc  <= '0;
            r_res  <= '0;
            r_div0 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt <= CNT_W'(WIDTH - 1);
                        r_dr  <= DR;
                        if (DR != '0) begin
                            r_acc <= {{WIDTH{1'b0}}, DV};
                        end else begin
                            r_coc  <= '1;
                            r_res  <= DV;
                            r_div0 <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_step_a;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_coc  <= w_step_a[WIDTH-1:0];
                        r_res  <= w_step_a[2*WIDTH-1:WIDTH];
                        r_div0 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cociente = r_coc;
    assign residuo  = r_res;
    assign div0     = r_div0;

`ifdef DIVISOR_DEBUG_EN
    assign testN    = r_cnt;
    assign testZ    = w_step_z;
    assign testDone = (r_state == ST_DONE);
    assign testDV   = r_acc;
    assign testdv0  = r_acc[0];
`else
    logic w_unused;
    assign w_unused = w_step_z;
`endif

endmodule
